// File: rtl/alu_iter_unit.sv
// ALU with the same 4-bit alu_ctr decode as alu_ctr, behind a valid/ready handshake.
// Arithmetic, logic and compare ops finish in one cycle; shifts iterate SHIFT_STEP bits per cycle.
module alu_iter_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int SHW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctr,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            err,
    output logic            busy
);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shop_t;

    // rem carries one spare bit so a SHIFT_STEP equal to XLEN still fits
    localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

    state_t          state_q, state_d;
    shop_t           shop_q, shop_d, shop_in;
    logic            out_valid_q, out_valid_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW:0]    rem_q, rem_d;

    logic [XLEN-1:0] fast_result;
    logic            fast_err;
    logic            is_shift;
    logic [SHW-1:0]  shamt;
    logic [SHW:0]    step_n;
    logic [SHW:0]    rem_next;
    logic [XLEN-1:0] shifted;

    assign shamt     = src_b[SHW-1:0];
    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = (state_q == SHIFT);

    // Single-cycle datapath; shift codes only flag the op and pass src_a for the zero-amount case
    always_comb begin
        fast_result = '0;
        fast_err    = 1'b0;
        is_shift    = 1'b0;
        shop_in     = SH_SLL;
        case (alu_ctr)
            4'b0000: fast_result = src_a + src_b;
            4'b1000: fast_result = src_a - src_b;
            4'b0010: fast_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0011: fast_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'b0100: fast_result = src_a ^ src_b;
            4'b0110: fast_result = src_a | src_b;
            4'b0111: fast_result = src_a & src_b;
            4'b0001: begin
                is_shift    = 1'b1;
                shop_in     = SH_SLL;
                fast_result = src_a;
            end
            4'b0101: begin
                is_shift    = 1'b1;
                shop_in     = SH_SRL;
                fast_result = src_a;
            end
            4'b1101: begin
                is_shift    = 1'b1;
                shop_in     = SH_SRA;
                fast_result = src_a;
            end
            default: fast_err = 1'b1;
        endcase
    end

    // SRA keeps work's MSB, which is always the original src_a sign bit
    always_comb begin
        step_n   = (rem_q < STEP) ? rem_q : STEP;
        rem_next = rem_q - step_n;
        case (shop_q)
            SH_SLL:  shifted = work_q << step_n;
            SH_SRL:  shifted = work_q >> step_n;
            SH_SRA:  shifted = $signed(work_q) >>> step_n;
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        shop_d      = shop_q;
        out_valid_d = out_valid_q && !out_ready;
        err_d       = err_q;
        result_d    = result_q;
        work_d      = work_q;
        rem_d       = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d = SHIFT;
                        work_d  = src_a;
                        rem_d   = {1'b0, shamt};
                        shop_d  = shop_in;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = fast_result;
                        err_d       = fast_err;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    out_valid_d = 1'b1;
                    result_d    = shifted;
                    err_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shop_q      <= SH_SLL;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            work_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            shop_q      <= shop_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            result_q    <= result_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
        end
    end

endmodule

// File: tb/tb_alu_iter_unit.sv
// Directed bench for alu_iter_unit: one instance with SHIFT_STEP=1, one with SHIFT_STEP=4.
module tb_alu_iter_unit;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, err, busy;
    logic [3:0]  alu_ctr;
    logic [31:0] src_a, src_b, result;

    logic        in_valid_4, in_ready_4, out_valid_4, out_ready_4, err_4, busy_4;
    logic [3:0]  alu_ctr_4;
    logic [31:0] src_a_4, src_b_4, result_4;

    int tests;
    int fails;

    alu_iter_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .alu_ctr(alu_ctr),
        .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err), .busy(busy)
    );

    alu_iter_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_4), .in_ready(in_ready_4), .alu_ctr(alu_ctr_4),
        .src_a(src_a_4), .src_b(src_b_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .result(result_4), .err(err_4), .busy(busy_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one request for exactly one edge on the SHIFT_STEP=1 instance
    task automatic applyStimulus(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_ctr  = ctr;
        src_a    = a;
        src_b    = b;
        tick();
        in_valid = 1'b0;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'hDEAD_BEEF;
    endtask

    task automatic runShift(input string tag, input logic [3:0] ctr, input logic [31:0] a,
                            input logic [31:0] b, input int cycles, input logic [31:0] expected);
        applyStimulus(ctr, a, b);
        for (int i = 0; i < cycles; i++) begin
            checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
            checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
            checkOutput({tag, "_out_valid_low"}, {31'b0, out_valid}, 32'd0);
            tick();
        end
        checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_result"}, result, expected);
        checkOutput({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_ctr     = 4'b0000;
        src_a       = '0;
        src_b       = '0;
        out_ready   = 1'b1;
        in_valid_4  = 1'b0;
        alu_ctr_4   = 4'b0000;
        src_a_4     = '0;
        src_b_4     = '0;
        out_ready_4 = 1'b1;

        tick();
        tick();
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        applyStimulus(4'b0000, 32'd5, 32'd7);
        checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add_result", result, 32'd12);
        checkOutput("add_err", {31'b0, err}, 32'd0);
        tick();
        checkOutput("add_consumed", {31'b0, out_valid}, 32'd0);

        // Back-to-back issue with in_valid held high
        in_valid = 1'b1;
        alu_ctr  = 4'b1000; src_a = 32'd3; src_b = 32'd5;
        tick();
        checkOutput("sub_result", result, 32'hFFFF_FFFE);
        checkOutput("sub_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("b2b_ready0", {31'b0, in_ready}, 32'd1);
        alu_ctr  = 4'b0010; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
        tick();
        checkOutput("slt_result", result, 32'd1);
        checkOutput("b2b_ready1", {31'b0, in_ready}, 32'd1);
        alu_ctr  = 4'b0011;
        tick();
        checkOutput("sltu_result", result, 32'd0);
        checkOutput("sltu_valid", {31'b0, out_valid}, 32'd1);
        alu_ctr  = 4'b0110; src_a = 32'h0F0F_0000; src_b = 32'h0000_00F0;
        tick();
        checkOutput("or_result", result, 32'h0F0F_00F0);
        alu_ctr  = 4'b0100; src_a = 32'hFF00_FF00; src_b = 32'h0FF0_0FF0;
        tick();
        checkOutput("xor_result", result, 32'hF0F0_F0F0);
        alu_ctr  = 4'b0111;
        tick();
        checkOutput("and_result", result, 32'h0F00_0F00);
        in_valid = 1'b0;
        tick();
        checkOutput("b2b_drained", {31'b0, out_valid}, 32'd0);

        runShift("sra", 4'b1101, 32'h8000_0000, 32'd4, 4, 32'hF800_0000);
        runShift("srl", 4'b0101, 32'h8000_0000, 32'd4, 4, 32'h0800_0000);
        runShift("sll", 4'b0001, 32'd1, 32'h25, 5, 32'h0000_0020);

        applyStimulus(4'b0101, 32'h1234_5678, 32'h0000_0020);
        checkOutput("shift0_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("shift0_result", result, 32'h1234_5678);
        checkOutput("shift0_busy", {31'b0, busy}, 32'd0);
        tick();

        // Backpressure: the held result must not move while out_ready is low
        out_ready = 1'b0;
        applyStimulus(4'b0000, 32'd10, 32'd20);
        checkOutput("bp_valid0", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_result0", result, 32'd30);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
            checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_result", result, 32'd30);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_comb", {31'b0, in_ready}, 32'd1);
        tick();
        checkOutput("bp_released", {31'b0, out_valid}, 32'd0);
        checkOutput("bp_in_ready_after", {31'b0, in_ready}, 32'd1);

        applyStimulus(4'b1111, 32'd9, 32'd9);
        checkOutput("illegal_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("illegal_result", result, 32'd0);
        checkOutput("illegal_err", {31'b0, err}, 32'd1);
        tick();

        // Abort a long SRA with reset two cycles into the shift
        applyStimulus(4'b1101, 32'h8000_0000, 32'd10);
        tick();
        tick();
        checkOutput("abort_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_err", {31'b0, err}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("abort_no_valid", {31'b0, out_valid}, 32'd0);
        end
        applyStimulus(4'b0000, 32'd2, 32'd3);
        checkOutput("post_abort_add", result, 32'd5);
        checkOutput("post_abort_valid", {31'b0, out_valid}, 32'd1);
        tick();

        // SHIFT_STEP=4 instance: SLL by 31 takes ceil(31/4)=8 iterations
        in_valid_4 = 1'b1;
        alu_ctr_4  = 4'b0001;
        src_a_4    = 32'd1;
        src_b_4    = 32'd31;
        tick();
        in_valid_4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("s4_busy", {31'b0, busy_4}, 32'd1);
            checkOutput("s4_out_valid_low", {31'b0, out_valid_4}, 32'd0);
            tick();
        end
        checkOutput("s4_sll_valid", {31'b0, out_valid_4}, 32'd1);
        checkOutput("s4_sll_result", result_4, 32'h8000_0000);
        tick();

        in_valid_4 = 1'b1;
        alu_ctr_4  = 4'b1101;
        src_a_4    = 32'h8000_0000;
        src_b_4    = 32'd6;
        tick();
        in_valid_4 = 1'b0;
        tick();
        checkOutput("s4_sra_mid", {31'b0, out_valid_4}, 32'd0);
        tick();
        checkOutput("s4_sra_valid", {31'b0, out_valid_4}, 32'd1);
        checkOutput("s4_sra_result", result_4, 32'hFE00_0000);
        tick();

        in_valid_4 = 1'b1;
        alu_ctr_4  = 4'b0001;
        src_a_4    = 32'hA5A5_0001;
        src_b_4    = 32'hFFFF_FFE0;
        tick();
        in_valid_4 = 1'b0;
        checkOutput("s4_zero_valid", {31'b0, out_valid_4}, 32'd1);
        checkOutput("s4_zero_result", result_4, 32'hA5A5_0001);
        checkOutput("s4_zero_busy", {31'b0, busy_4}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
